// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the shift-and-add multiply sequencer and its borrowed-ALU port.
// ALU opcode values mirror the processor's ALUop encoding.
package alu_mul_seq_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_OP_ADD = 4'd0;
    localparam alu_op_t ALU_OP_SLL = 4'd7;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/grant port to the shared execute-stage ALU.
// master = the sequencer borrowing the ALU, slave = arbiter/ALU side.
interface alu_mul_seq_if
    import alu_mul_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
);

    logic             alu_req;
    logic             alu_gnt;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    alu_op_t          alu_op;
    logic [WIDTH-1:0] alu_out;

    modport master (
        output alu_req,
        output alu_a,
        output alu_b,
        output alu_op,
        input  alu_gnt,
        input  alu_out
    );

    modport slave (
        input  alu_req,
        input  alu_a,
        input  alu_b,
        input  alu_op,
        output alu_gnt,
        output alu_out
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned multiply (low WIDTH bits) built from ADD/SLL micro-ops
// issued to a shared ALU; the sequencer itself holds only state and operands.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = DATA_WIDTH,
    parameter alu_op_t     OP_ADD = ALU_OP_ADD,
    parameter alu_op_t     OP_SLL = ALU_OP_SLL
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_kill,
    input  logic [WIDTH-1:0]  i_op_a,
    input  logic [WIDTH-1:0]  i_op_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [WIDTH-1:0]  o_result,
    alu_mul_seq_if.master     alu
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADD   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_d;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_d;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] w_mcand_d;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_mplier_d;
    logic [WIDTH-1:0] r_result;

    logic             w_alu_req;
    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    alu_op_t          w_alu_op;

    always_comb begin
        w_state_d  = r_state;
        w_acc_d    = r_acc;
        w_mcand_d  = r_mcand;
        w_mplier_d = r_mplier;
        w_alu_req  = 1'b0;
        w_alu_a    = '0;
        w_alu_b    = '0;
        w_alu_op   = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_acc_d    = '0;
                    w_mcand_d  = i_op_a;
                    w_mplier_d = i_op_b;
                    if (i_op_b == '0) begin
                        w_state_d = ST_DONE;
                    end else if (i_op_b[0]) begin
                        w_state_d = ST_ADD;
                    end else begin
                        w_state_d = ST_SHIFT;
                    end
                end
            end
            ST_ADD: begin
                w_alu_req = 1'b1;
                w_alu_a   = r_acc;
                w_alu_b   = r_mcand;
                w_alu_op  = OP_ADD;
                // kill outranks a same-cycle grant
                if (i_kill) begin
                    w_state_d = ST_IDLE;
                end else if (alu.alu_gnt) begin
                    w_acc_d   = alu.alu_out;
                    w_state_d = (r_mplier[WIDTH-1:1] == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_alu_req = 1'b1;
                w_alu_a   = r_mcand;
                w_alu_b   = WIDTH'(1);
                w_alu_op  = OP_SLL;
                if (i_kill) begin
                    w_state_d = ST_IDLE;
                end else if (alu.alu_gnt) begin
                    w_mcand_d  = alu.alu_out;
                    w_mplier_d = r_mplier >> 1;
                    w_state_d  = w_mplier_d[0] ? ST_ADD : ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_d;
            r_acc    <= w_acc_d;
            r_mcand  <= w_mcand_d;
            r_mplier <= w_mplier_d;
            // Capture on entry so result is already valid in the done cycle
            if (w_state_d == ST_DONE) begin
                r_result <= w_acc_d;
            end
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_result    = r_result;
    assign alu.alu_req = w_alu_req;
    assign alu.alu_a   = w_alu_a;
    assign alu.alu_b   = w_alu_b;
    assign alu.alu_op  = w_alu_op;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: behavioural ALU, random grant, and a
// product/latency reference model computed from plain arithmetic.
module tb_alu_mul_seq;
    import alu_mul_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        gnt;

    int errors = 0;
    int checks = 0;

    alu_mul_seq_if alu_bus ();

    alu_mul_seq u_dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_kill   (kill),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result),
        .alu      (alu_bus.master)
    );

    // Behavioural stand-in for the shared execute-stage ALU
    always_comb begin
        case (alu_bus.alu_op)
            ALU_OP_ADD: alu_bus.alu_out = alu_bus.alu_a + alu_bus.alu_b;
            ALU_OP_SLL: alu_bus.alu_out = alu_bus.alu_a << alu_bus.alu_b[4:0];
            default:    alu_bus.alu_out = '0;
        endcase
    end
    assign alu_bus.alu_gnt = gnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_latency(input logic [31:0] b);
        int msb;
        msb = 0;
        if (b == 32'd0) return 1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        return 1 + $countones(b) + msb;
    endfunction

    // Drives one multiply; cycles counts from the start cycle to the done cycle.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int gnt_pct,
                           output logic [31:0] res, output int cycles, output int reqs,
                           output int stalls, output bit timeout);
        res = '0; cycles = 0; reqs = 0; stalls = 0; timeout = 1'b1;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1; gnt = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (done) begin
                res = result;
                timeout = 1'b0;
                break;
            end
            if (alu_bus.alu_req) begin
                reqs++;
                gnt = (int'($urandom_range(99, 0)) < gnt_pct);
                if (!gnt) stalls++;
            end else begin
                gnt = 1'b1;
            end
        end
        gnt = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; kill = 1'b0; op_a = '0; op_b = '0; gnt = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, alu_bus.alu_req} !== 3'b000 || result !== 32'd0 ||
            alu_bus.alu_a !== 32'd0 || alu_bus.alu_b !== 32'd0 || alu_bus.alu_op !== 4'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b req=%b result=%h a=%h b=%h op=%h, required all 0",
                     busy, done, alu_bus.alu_req, result, alu_bus.alu_a, alu_bus.alu_b,
                     alu_bus.alu_op);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int cyc, reqs, stl;
        bit to;
        run_mul(32'd3, 32'd5, 100, res, cyc, reqs, stl, to);
        checks++;
        if (to || res !== 32'd15) begin
            errors++; $display("FAIL basic_result: got %0d (timeout=%0b), required 15", res, to);
        end
        checks++;
        if (cyc !== 5) begin
            errors++; $display("FAIL basic_latency: got %0d cycles, required 5", cyc);
        end
        checks++;
        if (reqs !== 4) begin
            errors++; $display("FAIL basic_req_count: got %0d, required 4", reqs);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_zero();
        logic [31:0] res;
        int cyc, reqs, stl;
        bit to;
        run_mul(32'h12345678, 32'd0, 100, res, cyc, reqs, stl, to);
        checks++;
        if (to || res !== 32'd0 || cyc !== 1 || reqs !== 0) begin
            errors++;
            $display("FAIL zero_mplier: result=%h cycles=%0d reqs=%0d, required 0 1 0",
                     res, cyc, reqs);
        end
    endtask

    task automatic test_max();
        logic [31:0] res;
        int cyc, reqs, stl;
        bit to;
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 100, res, cyc, reqs, stl, to);
        checks++;
        if (to || res !== 32'h1) begin
            errors++; $display("FAIL max_result: got %h, required 00000001", res);
        end
        checks++;
        if (cyc !== 64) begin
            errors++; $display("FAIL max_latency: got %0d, required 64", cyc);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, prod;
        int cyc, reqs, stl;
        bit to;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(31, 0);
            prod = a * b;
            run_mul(a, b, (i < 100) ? 100 : 60, res, cyc, reqs, stl, to);
            checks++;
            if (to || res !== prod) begin
                errors++;
                $display("FAIL rand_result: %h*%h got %h, required %h", a, b, res, prod);
            end
            checks++;
            if (cyc !== exp_latency(b) + stl) begin
                errors++;
                $display("FAIL rand_latency: b=%h got %0d, required %0d", b, cyc,
                         exp_latency(b) + stl);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] sa, sb;
        alu_op_t sop;
        int cyc;
        bit seen;
        @(negedge clk);
        op_a = 32'd7; op_b = 32'd6; start = 1'b1; gnt = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        checks++;
        if (alu_bus.alu_req !== 1'b1 || alu_bus.alu_op !== ALU_OP_SLL ||
            alu_bus.alu_a !== 32'd7 || alu_bus.alu_b !== 32'd1) begin
            errors++;
            $display("FAIL stall_first_shift: req=%b op=%h a=%h b=%h, required 1 7 7 1",
                     alu_bus.alu_req, alu_bus.alu_op, alu_bus.alu_a, alu_bus.alu_b);
        end
        sa = alu_bus.alu_a; sb = alu_bus.alu_b; sop = alu_bus.alu_op;
        gnt = 1'b0;
        repeat (2) begin
            @(negedge clk); cyc++;
            checks++;
            if (alu_bus.alu_req !== 1'b1 || alu_bus.alu_a !== sa || alu_bus.alu_b !== sb ||
                alu_bus.alu_op !== sop) begin
                errors++;
                $display("FAIL stall_hold: req=%b a=%h b=%h op=%h, required 1 %h %h %h",
                         alu_bus.alu_req, alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_op,
                         sa, sb, sop);
            end
        end
        @(negedge clk); cyc++;
        gnt = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk); cyc++;
        end
        checks++;
        if (!seen || result !== 32'd42 || cyc !== 8) begin
            errors++;
            $display("FAIL stall_result: result=%0d cycles=%0d done=%b, required 42 8 1",
                     result, cyc, seen);
        end
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int cyc, reqs, stl;
        bit to, saw_done;
        run_mul(32'd6, 32'd7, 100, res, cyc, reqs, stl, to);
        @(negedge clk);
        op_a = 32'd9; op_b = 32'hF; start = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) saw_done = 1'b1;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_bus.alu_req !== 1'b0 || saw_done) begin
            errors++;
            $display("FAIL kill_abort: busy=%b done=%b req=%b early_done=%b, required all 0",
                     busy, done, alu_bus.alu_req, saw_done);
        end
        checks++;
        if (result !== 32'd42) begin
            errors++; $display("FAIL kill_result_held: got %0d, required 42", result);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL kill_quiet: done=%b busy=%b, required 0 0", done, busy);
        end
        run_mul(32'd2, 32'd3, 100, res, cyc, reqs, stl, to);
        checks++;
        if (to || res !== 32'd6) begin
            errors++; $display("FAIL kill_restart: got %0d, required 6", res);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int cyc, reqs, stl;
        bit to;
        @(negedge clk);
        op_a = 32'd5; op_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (alu_bus.alu_req !== 1'b1 || alu_bus.alu_op !== ALU_OP_ADD) begin
            errors++;
            $display("FAIL areset_in_add: req=%b op=%h, required 1 0",
                     alu_bus.alu_req, alu_bus.alu_op);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, alu_bus.alu_req} !== 3'b000 || result !== 32'd0 ||
            alu_bus.alu_a !== 32'd0 || alu_bus.alu_b !== 32'd0 || alu_bus.alu_op !== 4'd0) begin
            errors++;
            $display("FAIL areset_outputs: busy=%b done=%b req=%b result=%h a=%h b=%h op=%h, required all 0",
                     busy, done, alu_bus.alu_req, result, alu_bus.alu_a, alu_bus.alu_b,
                     alu_bus.alu_op);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_mul(32'd4, 32'd4, 100, res, cyc, reqs, stl, to);
        checks++;
        if (to || res !== 32'd16 || cyc !== 4) begin
            errors++;
            $display("FAIL areset_restart: result=%0d cycles=%0d, required 16 4", res, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_stall();
        test_kill();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
